lpif_tx_arbiter: RTL
====================

Name: lpif_tx_arbiter

Overview:
- Link-layer transmit scheduler in front of the LPIF transmit datapath (Data/Valid/Irdy/trdy, tlp_start/end, dllp_start/end).
- Arbitrates whole packets between a TLP source and a DLLP source and drives the LPIF Irdy/trdy handshake.
- Generates the start/end byte-lane markers.
- Gates traffic on link_up/state_sts, and honours the PHY stall_req/stall_ack protocol at packet boundaries.

Parameters:
- ACTIVE_ENC, 4'h1, state_sts encoding for ACTIVE; traffic is only launched in this state.
- MAX_DLLP_RUN, 4, consecutive DLLP packets granted while a TLP waits before the TLP is forced through (range 1..15).

Ports:
- Clk  input  1  clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising Clk)
- tlp_valid / dllp_valid  input  1  source beat valid
- tlp_data / dllp_data  input  64  source beat, byte lane i = bits [8i+7:8i]
- tlp_bvalid / dllp_bvalid  input  8  byte-lane valid, contiguous from lane 0
- tlp_sop / dllp_sop  input  1  first beat of packet (packet begins at lane 0)
- tlp_eop / dllp_eop  input  1  last beat of packet
- tlp_ready / dllp_ready  output  1  source beat accepted when valid&&ready
- link_up  input  1  link up from PHY
- state_sts  input  4  PHY link state
- trdy  input  1  PHY ready; LPIF beat transfers when Irdy&&trdy
- stall_req  input  1  PHY stall request
- Data  output  64  LPIF transmit data
- Valid  output  8  LPIF byte valid
- Irdy  output  1  LPIF data valid
- tlp_start / tlp_end / dllp_start / dllp_end  output  9  lane markers
- stall_ack  output  1  stall acknowledge

Behaviour:
- Reset (reset=0 at a Clk edge): all outputs 0, FSM=IDLE, starvation counter=0, output register empty. This applies mid-packet: the partial packet is abandoned and the bench must not expect its completion.
- Single output register holding Data, Valid, markers and Irdy.
  - Irdy=1 means the register is full.
  - While Irdy&&!trdy, every output holds stable.
- Load condition: load = granted source valid && (!Irdy || trdy) && FSM in TLP/DLLP.
- Source ready: the granted source's ready = (!Irdy || trdy) in TLP/DLLP (combinational on trdy). The non-granted source's ready=0.
- Load latency: a source beat appears on Data exactly 1 cycle after its transfer. Sustained throughput is 1 beat/cycle while trdy=1.
- Markers on loaded beats:
  - sop beat: *_start=9'h001.
  - eop beat: *_end one-hot at lane (highest set bvalid bit). Example: bvalid=8'h0F gives 9'h008.
  - Bit 8 is always 0.
  - The other packet type's markers are 0.
  - Unload with no reload clears Irdy and all markers.
- tx_ok = link_up && state_sts==ACTIVE_ENC.
- FSM:
  - IDLE:
    - If stall_req → STALL.
    - Else if !tx_ok → stay.
    - Else if dllp_valid&&dllp_sop and !(tlp_valid && cnt>=MAX_DLLP_RUN) → DLLP, and cnt+=1 if tlp_valid (saturating).
    - Else if tlp_valid → TLP, cnt=0.
    - Same-cycle DLLP and TLP requests: DLLP wins unless the starvation limit is reached.
  - TLP/DLLP:
    - Forward beats.
    - Transfer of an eop beat → IDLE; the next grant decision can happen the following cycle.
    - stall_req asserted mid-packet is ignored until eop.
    - If tx_ok drops mid-packet → FLUSH.
      - An already-loaded beat in the output register still completes its handshake.
  - FLUSH:
    - Granted source ready=1, nothing is loaded, beats are discarded.
    - Transfer of the eop beat → IDLE.
  - STALL:
    - stall_ack=1 (registered) once Irdy=0, in the cycle after entry at earliest.
    - No grants are made.
    - stall_req=0 → stall_ack=0 next cycle, FSM → IDLE.
- A source presenting valid without sop in IDLE is not granted; it is held (ready=0).
- Starvation counter is 4 bits and saturates at 15.

Test Plan:
- Link ACTIVE, trdy=1, 3-beat TLP (last bvalid=8'h0F) → Data appears 1 cycle after each transfer; tlp_start=9'h001 on beat 0; tlp_end=9'h008 on beat 2; dllp_* remain 0.
- Backpressure: trdy low for 3 cycles mid-packet → Data/Valid/Irdy held constant; tlp_ready=0 throughout; no beat lost or duplicated.
- TLP and 1-beat DLLPs both continuously pending, MAX_DLLP_RUN=4 → grant order DLLP×4, TLP, DLLP×4, TLP.
- stall_req rises during beat 1 of a 4-beat TLP → packet completes; stall_ack=1 the cycle after Irdy falls; stall_req low → stall_ack=0 next cycle and traffic resumes.
- state_sts leaves ACTIVE after beat 1 of 4 → beats 2-3 accepted and discarded with Irdy=0; FSM returns to IDLE; no grant until state_sts=ACTIVE again.
- reset=0 for 1 cycle mid-packet → all outputs 0 next cycle; next granted packet starts with sop markers correct.

Source files
------------

// File: rtl/lpif_tx_arbiter.sv
// LPIF transmit scheduler: packet-level TLP/DLLP arbitration into a single
// output register, with start/end lane markers, link gating and stall handshake.
module lpif_tx_arbiter #(
   parameter logic [3:0]  ACTIVE_ENC   = 4'h1,
   parameter int unsigned MAX_DLLP_RUN = 4
) (
   input  logic        Clk,
   input  logic        reset,
   input  logic        tlp_valid,
   input  logic [63:0] tlp_data,
   input  logic [7:0]  tlp_bvalid,
   input  logic        tlp_sop,
   input  logic        tlp_eop,
   output logic        tlp_ready,
   input  logic        dllp_valid,
   input  logic [63:0] dllp_data,
   input  logic [7:0]  dllp_bvalid,
   input  logic        dllp_sop,
   input  logic        dllp_eop,
   output logic        dllp_ready,
   input  logic        link_up,
   input  logic [3:0]  state_sts,
   input  logic        trdy,
   input  logic        stall_req,
   output logic [63:0] Data,
   output logic [7:0]  Valid,
   output logic        Irdy,
   output logic [8:0]  tlp_start,
   output logic [8:0]  tlp_end,
   output logic [8:0]  dllp_start,
   output logic [8:0]  dllp_end,
   output logic        stall_ack
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TLP   = 3'd1;
   localparam logic [2:0] S_DLLP  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_STALL = 3'd4;

   logic [2:0]  state;
   logic [3:0]  cnt;
   logic        flush_tlp;
   logic        tx_ok, free, tlp_req, dllp_req, starve;
   logic        tlp_fire, dllp_fire, load, is_tlp;
   logic [63:0] src_data;
   logic [7:0]  src_bv;
   logic        src_sop, src_eop;
   logic [2:0]  hi_lane;
   logic [8:0]  start_mark, end_mark;

   assign tx_ok    = link_up && (state_sts == ACTIVE_ENC);
   assign free     = !Irdy || trdy;
   assign tlp_req  = tlp_valid && tlp_sop;
   assign dllp_req = dllp_valid && dllp_sop;
   assign starve   = tlp_req && (cnt >= 4'(MAX_DLLP_RUN));

   // Beats are only forwarded while tx_ok holds; once it drops the rest of
   // the packet is drained through FLUSH without touching the output register.
   assign tlp_ready  = ((state == S_TLP)  && tx_ok && free) || ((state == S_FLUSH) &&  flush_tlp);
   assign dllp_ready = ((state == S_DLLP) && tx_ok && free) || ((state == S_FLUSH) && !flush_tlp);
   assign tlp_fire   = tlp_valid  && tlp_ready;
   assign dllp_fire  = dllp_valid && dllp_ready;
   assign load       = ((state == S_TLP) && tlp_fire) || ((state == S_DLLP) && dllp_fire);

   assign is_tlp   = (state == S_TLP);
   assign src_data = is_tlp ? tlp_data   : dllp_data;
   assign src_bv   = is_tlp ? tlp_bvalid : dllp_bvalid;
   assign src_sop  = is_tlp ? tlp_sop    : dllp_sop;
   assign src_eop  = is_tlp ? tlp_eop    : dllp_eop;

   always_comb begin
      hi_lane = '0;
      for (int i = 0; i < 8; i++)
         if (src_bv[i]) hi_lane = 3'(i);
   end

   assign start_mark = src_sop ? 9'h001 : 9'h000;
   assign end_mark   = src_eop ? (9'h001 << hi_lane) : 9'h000;

   always_ff @(posedge Clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         flush_tlp  <= 1'b0;
         Data       <= '0;
         Valid      <= '0;
         Irdy       <= 1'b0;
         tlp_start  <= '0;
         tlp_end    <= '0;
         dllp_start <= '0;
         dllp_end   <= '0;
         stall_ack  <= 1'b0;
      end else begin
         if (load) begin
            Data       <= src_data;
            Valid      <= src_bv;
            Irdy       <= 1'b1;
            tlp_start  <= is_tlp ? start_mark : 9'h000;
            tlp_end    <= is_tlp ? end_mark   : 9'h000;
            dllp_start <= is_tlp ? 9'h000 : start_mark;
            dllp_end   <= is_tlp ? 9'h000 : end_mark;
         end else if (Irdy && trdy) begin
            Data       <= '0;
            Valid      <= '0;
            Irdy       <= 1'b0;
            tlp_start  <= '0;
            tlp_end    <= '0;
            dllp_start <= '0;
            dllp_end   <= '0;
         end

         // Acknowledge only after the last beat has left the register.
         stall_ack <= (state == S_STALL) && stall_req && !Irdy;

         case (state)
            S_IDLE: begin
               if (stall_req)
                  state <= S_STALL;
               else if (tx_ok) begin
                  if (dllp_req && !starve) begin
                     state <= S_DLLP;
                     if (tlp_req && cnt != 4'hF) cnt <= cnt + 4'd1;
                  end else if (tlp_req) begin
                     state <= S_TLP;
                     cnt   <= '0;
                  end
               end
            end
            S_TLP: begin
               if (!tx_ok) begin
                  state     <= S_FLUSH;
                  flush_tlp <= 1'b1;
               end else if (tlp_fire && tlp_eop)
                  state <= S_IDLE;
            end
            S_DLLP: begin
               if (!tx_ok) begin
                  state     <= S_FLUSH;
                  flush_tlp <= 1'b0;
               end else if (dllp_fire && dllp_eop)
                  state <= S_IDLE;
            end
            S_FLUSH: begin
               if ((flush_tlp && tlp_fire && tlp_eop) || (!flush_tlp && dllp_fire && dllp_eop))
                  state <= S_IDLE;
            end
            S_STALL: begin
               if (!stall_req) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
